// File: rtl/hist_peak_finder_pkg.sv
// Shared sizing constants and FSM state encoding for the histogram peak finder.
package hist_peak_finder_pkg;

    localparam int BIN_NUM   = 256;
    localparam int BIN_W     = 8;
    localparam int CNT_W     = 10;
    localparam int PIXEL_NUM = 200;
    localparam int PIX_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SCAN  = 2'b01,
        DRAIN = 2'b10,
        OUT   = 2'b11
    } state_e;

endpackage

// File: rtl/hist_peak_finder_if.sv
// Histogram RAM read port plus the peak record valid/ready channel.
// The master side belongs to the peak finder, the slave side to the RAM/consumer.
interface hist_peak_finder_if #(
    parameter int BIN_W = hist_peak_finder_pkg::BIN_W,
    parameter int CNT_W = hist_peak_finder_pkg::CNT_W,
    parameter int PIX_W = hist_peak_finder_pkg::PIX_W
) ();
    import hist_peak_finder_pkg::*;

    logic             rd_en;
    logic             rd_bank;
    logic [PIX_W-1:0] rd_pix;
    logic [BIN_W-1:0] rd_bin;
    logic [CNT_W-1:0] rd_data;

    logic             peak_valid;
    logic             peak_ready;
    logic [PIX_W-1:0] peak_pix;
    logic [BIN_W-1:0] peak_bin;
    logic [CNT_W-1:0] peak_cnt;

    modport master (
        output rd_en, rd_bank, rd_pix, rd_bin,
        input  rd_data,
        output peak_valid, peak_pix, peak_bin, peak_cnt,
        input  peak_ready
    );

    modport slave (
        input  rd_en, rd_bank, rd_pix, rd_bin,
        output rd_data,
        input  peak_valid, peak_pix, peak_bin, peak_cnt,
        output peak_ready
    );

endinterface

// File: rtl/hist_peak_finder_peak_max_tracker.sv
// Running maximum of returned bin counts; strict-greater update so ties keep the lowest bin.
module peak_max_tracker #(
    parameter int BIN_W = hist_peak_finder_pkg::BIN_W,
    parameter int CNT_W = hist_peak_finder_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             res,
    input  logic             clear,
    input  logic             data_valid,
    input  logic [BIN_W-1:0] data_bin,
    input  logic [CNT_W-1:0] data,
    output logic [CNT_W-1:0] max_cnt,
    output logic [BIN_W-1:0] max_bin
);
    import hist_peak_finder_pkg::*;

    logic [CNT_W-1:0] max_cnt_q, max_cnt_d;
    logic [BIN_W-1:0] max_bin_q, max_bin_d;

    always_comb begin
        max_cnt_d = max_cnt_q;
        max_bin_d = max_bin_q;
        if (clear) begin
            max_cnt_d = '0;
            max_bin_d = '0;
        end else if (data_valid && (data > max_cnt_q)) begin
            max_cnt_d = data;
            max_bin_d = data_bin;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            max_cnt_q <= '0;
            max_bin_q <= '0;
        end else begin
            max_cnt_q <= max_cnt_d;
            max_bin_q <= max_bin_d;
        end
    end

    assign max_cnt = max_cnt_q;
    assign max_bin = max_bin_q;

endmodule

// File: rtl/hist_peak_finder.sv
// Scans each completed histogram bank pixel by pixel and emits one
// (pixel, peak bin, peak count) record per pixel over valid/ready.
module hist_peak_finder #(
    parameter int BIN_NUM   = hist_peak_finder_pkg::BIN_NUM,
    parameter int BIN_W     = hist_peak_finder_pkg::BIN_W,
    parameter int CNT_W     = hist_peak_finder_pkg::CNT_W,
    parameter int PIXEL_NUM = hist_peak_finder_pkg::PIXEL_NUM,
    parameter int PIX_W     = hist_peak_finder_pkg::PIX_W
) (
    input  logic                clk,
    input  logic                res,
    input  logic                his_num,
    hist_peak_finder_if.master  bus,
    output logic                busy,
    output logic                overrun
);
    import hist_peak_finder_pkg::*;

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(BIN_NUM - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXEL_NUM - 1);

    state_e           state_q, state_d;
    logic             his_num_q;
    logic             toggle_q, toggle_d;
    logic             toggle_bank_q;
    logic             pending_q, pending_d;
    logic             pend_bank_q, pend_bank_d;
    logic             bank_q, bank_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic             data_valid_q;
    logic [BIN_W-1:0] data_bin_q;

    logic             rd_en;
    logic             clear;
    logic             start;
    logic             start_bank;
    logic             consume;
    logic             toggle_used;
    logic [CNT_W-1:0] max_cnt;
    logic [BIN_W-1:0] max_bin;

    assign toggle_d = his_num ^ his_num_q;
    assign rd_en    = (state_q == SCAN);

    // A start either comes from a fresh toggle or from the one parked in pending;
    // any toggle not used to start is parked, or dropped with overrun if the slot is taken.
    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        pix_d       = pix_q;
        bin_d       = bin_q;
        pending_d   = pending_q;
        pend_bank_d = pend_bank_q;
        clear       = 1'b0;
        overrun     = 1'b0;
        start       = 1'b0;
        start_bank  = bank_q;
        consume     = 1'b0;
        toggle_used = 1'b0;

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    start      = 1'b1;
                    start_bank = pend_bank_q;
                    consume    = 1'b1;
                end else if (toggle_q) begin
                    start       = 1'b1;
                    start_bank  = toggle_bank_q;
                    toggle_used = 1'b1;
                end
            end
            SCAN: begin
                bin_d = bin_q + 1'b1;
                if (bin_q == LAST_BIN) begin
                    bin_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = OUT;
            end
            OUT: begin
                if (bus.peak_ready) begin
                    if (pix_q == LAST_PIX) begin
                        state_d = IDLE;
                        if (pending_q) begin
                            start      = 1'b1;
                            start_bank = pend_bank_q;
                            consume    = 1'b1;
                        end
                    end else begin
                        pix_d   = pix_q + 1'b1;
                        bin_d   = '0;
                        clear   = 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d = SCAN;
            bank_d  = start_bank;
            pix_d   = '0;
            bin_d   = '0;
            clear   = 1'b1;
        end

        if (consume) begin
            pending_d = 1'b0;
        end

        if (toggle_q && !toggle_used) begin
            if (pending_q && !consume) begin
                overrun = 1'b1;
            end else begin
                pending_d   = 1'b1;
                pend_bank_d = toggle_bank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q       <= IDLE;
            his_num_q     <= 1'b0;
            toggle_q      <= 1'b0;
            toggle_bank_q <= 1'b0;
            pending_q     <= 1'b0;
            pend_bank_q   <= 1'b0;
            bank_q        <= 1'b0;
            pix_q         <= '0;
            bin_q         <= '0;
            data_valid_q  <= 1'b0;
            data_bin_q    <= '0;
        end else begin
            state_q       <= state_d;
            his_num_q     <= his_num;
            toggle_q      <= toggle_d;
            toggle_bank_q <= his_num_q;
            pending_q     <= pending_d;
            pend_bank_q   <= pend_bank_d;
            bank_q        <= bank_d;
            pix_q         <= pix_d;
            bin_q         <= bin_d;
            data_valid_q  <= rd_en;
            data_bin_q    <= bin_q;
        end
    end

    peak_max_tracker #(
        .BIN_W (BIN_W),
        .CNT_W (CNT_W)
    ) u_tracker (
        .clk        (clk),
        .res        (res),
        .clear      (clear),
        .data_valid (data_valid_q),
        .data_bin   (data_bin_q),
        .data       (bus.rd_data),
        .max_cnt    (max_cnt),
        .max_bin    (max_bin)
    );

    assign bus.rd_en      = rd_en;
    assign bus.rd_bank    = bank_q;
    assign bus.rd_pix     = pix_q;
    assign bus.rd_bin     = bin_q;
    assign bus.peak_valid = (state_q == OUT);
    assign bus.peak_pix   = pix_q;
    assign bus.peak_bin   = max_bin;
    assign bus.peak_cnt   = max_cnt;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_hist_peak_finder.sv
// Scoreboard bench for hist_peak_finder: directed histograms with hand-computed peaks.
module tb_hist_peak_finder;

    localparam int BIN_NUM   = 8;
    localparam int BIN_W     = 3;
    localparam int CNT_W     = 10;
    localparam int PIXEL_NUM = 2;
    localparam int PIX_W     = 8;

    typedef struct {
        int bank;
        int pix;
        int bin;
        int cnt;
    } rec_t;

    typedef logic [CNT_W-1:0] hist_t [BIN_NUM];

    logic clk = 1'b0;
    logic res = 1'b0;
    logic his_num = 1'b0;
    logic busy;
    logic overrun;

    rec_t expQ[$];
    rec_t monRec;
    int   checks = 0;
    int   passes = 0;
    int   fails = 0;
    int   overrunCount = 0;
    logic [CNT_W-1:0] mem [2][PIXEL_NUM][BIN_NUM];

    hist_peak_finder_if #(.BIN_W(BIN_W), .CNT_W(CNT_W), .PIX_W(PIX_W)) bus ();

    hist_peak_finder #(
        .BIN_NUM   (BIN_NUM),
        .BIN_W     (BIN_W),
        .CNT_W     (CNT_W),
        .PIXEL_NUM (PIXEL_NUM),
        .PIX_W     (PIX_W)
    ) dut (
        .clk     (clk),
        .res     (res),
        .his_num (his_num),
        .bus     (bus.master),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    // Histogram RAM model: one-cycle read latency, junk value when not reading.
    always @(posedge clk) begin
        if (bus.rd_en)
            bus.rd_data <= mem[int'(bus.rd_bank)][int'(bus.rd_pix)][int'(bus.rd_bin)];
        else
            bus.rd_data <= 10'h3FF;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the expected record on every accepted output and checks read addressing.
    always @(negedge clk) begin
        if (res && bus.peak_valid && bus.peak_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedRecord", 1, 0);
            end else begin
                monRec = expQ.pop_front();
                checkOutput("peakPix", int'(bus.peak_pix), monRec.pix);
                checkOutput("peakBin", int'(bus.peak_bin), monRec.bin);
                checkOutput("peakCnt", int'(bus.peak_cnt), monRec.cnt);
            end
        end
        if (res && bus.rd_en && bus.rd_bin == '0 && expQ.size() > 0) begin
            checkOutput("rdBank", int'(bus.rd_bank), expQ[0].bank);
            checkOutput("rdPix", int'(bus.rd_pix), expQ[0].pix);
        end
        if (res && overrun) overrunCount++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        his_num = ~his_num;
    endtask

    task automatic loadPixel(input int bank, input int pix, input hist_t h);
        for (int i = 0; i < BIN_NUM; i++) mem[bank][pix][i] = h[i];
    endtask

    task automatic pushExp(input int bank, input int pix, input int bin, input int cnt);
        rec_t r;
        r.bank = bank;
        r.pix  = pix;
        r.bin  = bin;
        r.cnt  = cnt;
        expQ.push_back(r);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while ((expQ.size() != 0 || busy) && n < 400) begin
            tick(1);
            n++;
        end
        checkOutput({name, "QueueEmpty"}, expQ.size(), 0);
        checkOutput({name, "Idle"}, int'(busy), 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int idleCycles;
        int validSeen;

        for (int b = 0; b < 2; b++)
            for (int p = 0; p < PIXEL_NUM; p++)
                for (int i = 0; i < BIN_NUM; i++) mem[b][p][i] = '0;
        bus.peak_ready = 1'b1;

        tick(2);
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetRdEn", int'(bus.rd_en), 0);
        checkOutput("resetValid", int'(bus.peak_valid), 0);
        checkOutput("resetOverrun", int'(overrun), 0);
        checkOutput("resetPeakCnt", int'(bus.peak_cnt), 0);
        res = 1'b1;
        tick(2);

        $display("[TB] single peak");
        loadPixel(0, 0, '{0, 3, 9, 2, 0, 0, 1, 0});
        loadPixel(0, 1, '{5, 0, 0, 0, 0, 0, 0, 7});
        pushExp(0, 0, 2, 9);
        pushExp(0, 1, 7, 7);
        applyStimulus();
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!bus.rd_en && n < 10);
        checkOutput("firstRdLatency", n, 2);
        waitIdle("single");

        $display("[TB] tie and zero");
        loadPixel(1, 0, '{4, 4, 1, 0, 0, 0, 0, 0});
        loadPixel(1, 1, '{0, 0, 0, 0, 0, 0, 0, 0});
        pushExp(1, 0, 0, 4);
        pushExp(1, 1, 0, 0);
        applyStimulus();
        waitIdle("tie");

        $display("[TB] backpressure");
        loadPixel(0, 0, '{0, 0, 0, 0, 0, 0, 0, 12});
        loadPixel(0, 1, '{2, 0, 6, 6, 0, 0, 0, 0});
        pushExp(0, 0, 7, 12);
        pushExp(0, 1, 2, 6);
        bus.peak_ready = 1'b0;
        applyStimulus();
        n = 0;
        while (!bus.peak_valid && n < 100) begin
            tick(1);
            n++;
        end
        checkOutput("bpValidSeen", int'(bus.peak_valid), 1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stallValid", int'(bus.peak_valid), 1);
            checkOutput("stallPix", int'(bus.peak_pix), 0);
            checkOutput("stallBin", int'(bus.peak_bin), 7);
            checkOutput("stallCnt", int'(bus.peak_cnt), 12);
            checkOutput("stallRdEn", int'(bus.rd_en), 0);
            tick(1);
        end
        bus.peak_ready = 1'b1;
        tick(1);
        checkOutput("resumeRdEn", int'(bus.rd_en), 1);
        checkOutput("resumePix", int'(bus.rd_pix), 1);
        checkOutput("resumeBin", int'(bus.rd_bin), 0);
        waitIdle("backpressure");

        $display("[TB] pending bank");
        loadPixel(1, 0, '{0, 1, 0, 0, 0, 0, 0, 0});
        loadPixel(1, 1, '{0, 0, 0, 0, 0, 0, 3, 0});
        loadPixel(0, 0, '{9, 0, 0, 0, 0, 0, 0, 0});
        loadPixel(0, 1, '{0, 0, 0, 0, 0, 2, 0, 2});
        pushExp(1, 0, 1, 1);
        pushExp(1, 1, 6, 3);
        pushExp(0, 0, 0, 9);
        pushExp(0, 1, 5, 2);
        overrunCount = 0;
        applyStimulus();
        tick(5);
        applyStimulus();
        idleCycles = 0;
        n = 0;
        while (expQ.size() != 0 && n < 400) begin
            tick(1);
            n++;
            if (expQ.size() != 0 && !busy) idleCycles++;
        end
        checkOutput("pendingNoIdle", idleCycles, 0);
        checkOutput("pendingOverrun", overrunCount, 0);
        waitIdle("pending");

        $display("[TB] overrun");
        loadPixel(1, 0, '{0, 0, 5, 0, 0, 0, 0, 0});
        loadPixel(1, 1, '{0, 0, 0, 1, 0, 0, 0, 0});
        loadPixel(0, 0, '{0, 0, 0, 0, 8, 0, 0, 0});
        loadPixel(0, 1, '{0, 0, 0, 0, 0, 0, 0, 0});
        pushExp(1, 0, 2, 5);
        pushExp(1, 1, 3, 1);
        pushExp(0, 0, 4, 8);
        pushExp(0, 1, 0, 0);
        overrunCount = 0;
        applyStimulus();
        tick(4);
        applyStimulus();
        tick(4);
        applyStimulus();
        waitIdle("overrun");
        tick(20);
        checkOutput("overrunPulses", overrunCount, 1);
        checkOutput("overrunNoThirdScan", int'(busy), 0);

        $display("[TB] reset mid-scan");
        applyStimulus();
        n = 0;
        while (!(bus.rd_en && bus.rd_bin == 3'd4) && n < 100) begin
            tick(1);
            n++;
        end
        checkOutput("rstReachedBin4", int'(bus.rd_bin), 4);
        res = 1'b0;
        #1;
        checkOutput("rstRdEn", int'(bus.rd_en), 0);
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstRdBin", int'(bus.rd_bin), 0);
        checkOutput("rstValid", int'(bus.peak_valid), 0);
        his_num = 1'b0;
        tick(2);
        res = 1'b1;
        validSeen = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (bus.peak_valid) validSeen++;
        end
        checkOutput("rstNoRecord", validSeen, 0);
        checkOutput("rstStaysIdle", int'(busy), 0);

        pushExp(0, 0, 4, 8);
        pushExp(0, 1, 0, 0);
        applyStimulus();
        waitIdle("afterReset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hist_peak_finder.md
Name: hist_peak_finder

Overview:
- Downstream of the histogram builder. When the builder toggles its ping-pong bank flag, this block scans the just-completed bank bin by bin, one pixel at a time.
- It tracks the maximum count per pixel and emits one (pixel, peak bin, peak count) record per pixel over a valid/ready handshake to the depth/ToF calculation stage.

Parameters:
- BIN_NUM, 256, bins per pixel histogram (power of two)
- BIN_W, 8, bin index width = log2(BIN_NUM)
- CNT_W, 10, bin count width from the histogram RAM
- PIXEL_NUM, 200, pixels per bank
- PIX_W, 8, pixel index width

Ports:
- clk  in  1  system clock
- res  in  1  asynchronous active-low reset
- his_num  in  1  builder bank flag; each toggle marks one bank complete
- rd_en  out  1  histogram RAM read strobe
- rd_bank  out  1  bank to read (value of his_num before the toggle)
- rd_pix  out  PIX_W  pixel index of the read
- rd_bin  out  BIN_W  bin index of the read
- rd_data  in  CNT_W  bin count, valid exactly 1 cycle after rd_en
- peak_valid  out  1  result record valid
- peak_ready  in  1  consumer accepts record
- peak_pix  out  PIX_W  pixel of record
- peak_bin  out  BIN_W  bin with maximum count
- peak_cnt  out  CNT_W  maximum count
- busy  out  1  scan in progress (state != IDLE)
- overrun  out  1  one-cycle pulse when a bank completion is lost

Behaviour:
- Reset (res=0, async): all outputs 0, state IDLE, his_num_q=0, pending=0, max registers 0. Reset mid-scan aborts it; no partial record is ever emitted.
- Toggle detect: his_num != his_num_q, registered. his_num_q updates every cycle. A completed bank is the old his_num_q value.
- States: IDLE, SCAN, DRAIN, OUT.
  - IDLE:
    - On toggle: latch bank = his_num_q, pix=0, bin=0, max_cnt=0, max_bin=0; go SCAN next cycle.
    - If pending=1: start the same way using pend_bank; clear pending.
  - SCAN:
    - rd_en=1 every cycle with rd_bank/rd_pix/rd_bin; bin increments.
    - Compare path: when rd_data is valid and rd_data > max_cnt (strictly greater), update max_cnt/max_bin to that data and its bin (bin delayed 1 cycle). Ties keep the lowest bin.
    - After issuing bin BIN_NUM-1, go DRAIN.
  - DRAIN: rd_en=0; compare the last returned word; go OUT.
  - OUT:
    - peak_valid=1; peak_pix/peak_bin/peak_cnt hold stable until peak_valid&peak_ready.
    - On handshake with pix<PIXEL_NUM-1: pix+1, bin=0, max cleared, go SCAN.
    - On handshake with pix=PIXEL_NUM-1: go IDLE, or directly restart if pending.
- Latency: first rd_en 2 cycles after the his_num toggle edge (edge register, then state). peak_valid asserts BIN_NUM+1 cycles after the first rd_en of a pixel. With peak_ready tied high, throughput is BIN_NUM+2 cycles per pixel.
- All-zero histogram: peak_bin=0, peak_cnt=0.
- Toggle while busy:
  - pending=0: set pending=1 and store pend_bank.
  - pending=1: overrun pulses 1 cycle; the toggle is discarded; the pending bank is unchanged.
  - Toggle in the same cycle as the final handshake: it goes to pending and is serviced next cycle.
- Backpressure: stalls the scan; no reads are issued in OUT.
- Widths: counters wrap-free by construction. The comparator is unsigned CNT_W.

Decomposition:
- Shared package (parametersSiFH.vh style defines): BIN_NUM, BIN_W, CNT_W, PIXEL_NUM, PIX_W, and the state encodings (IDLE=2'b00, SCAN=2'b01, DRAIN=2'b10, OUT=2'b11).
- One sub-module, peak_max_tracker: takes data valid, bin index, rd_data, and clear; holds max_cnt/max_bin with strict-greater update.
- The FSM, address generation, pending/overrun logic and handshake live in the top.

Test Plan (BIN_NUM=8, PIXEL_NUM=2, CNT_W=10):
- Single peak: toggle his_num 0->1. Bank 0 pix0 = {0,3,9,2,0,0,1,0}, pix1 = {5,0,0,0,0,0,0,7}, peak_ready=1 -> records (0,2,9) then (1,7,7). rd_bank=0 throughout. First rd_en 2 cycles after the toggle.
- Tie and zero: pix0 = {4,4,1,...0}, pix1 = all 0 -> (0,0,4) and (1,0,0).
- Backpressure: peak_ready=0 for 5 cycles at the pix0 record -> peak_* stable; no rd_en during the stall; pix1 scan starts the cycle after the handshake.
- Pending: second toggle (1->0) mid-scan of pix0 -> after pix1's handshake, scan of bank 1 starts immediately with no IDLE cycle; overrun stays 0.
- Overrun: two extra toggles during one scan -> overrun pulses exactly once; only one pending bank is serviced.
- Reset mid-SCAN at bin 4 -> all outputs 0 immediately; no peak_valid after release until a new toggle.
